// File: rtl/sirene_driver.sv
// End-of-shift siren driver: turns a siren request level into a counted ON/OFF beep
// pattern on one LED, stopped by acknowledge, beep budget exhaustion or request drop.
module sirene_driver #(
  parameter int ON_CYCLES  = 4,
  parameter int OFF_CYCLES = 4,
  parameter int MAX_BEEPS  = 3
) (
  input  logic       clk_2,
  input  logic       reset_n,
  input  logic       sirene_req,
  input  logic       ack,
  output logic       buzzer,
  output logic       active,
  output logic [3:0] beep_count,
  output logic       done
);

  localparam int TMAX = (ON_CYCLES > OFF_CYCLES) ? ON_CYCLES : OFF_CYCLES;
  localparam int TW   = (TMAX > 1) ? $clog2(TMAX) : 1;

  typedef enum logic [1:0] {IDLE, ON, OFF, WAIT_CLEAR} state_t;

  state_t          state_reg, state_next;
  logic [TW-1:0]   timer_reg, timer_next;
  logic            req_d_reg;
  logic [3:0]      count_next;
  logic            done_next;
  logic            start;

  assign start = sirene_req & ~req_d_reg;

  always_comb begin
    state_next = state_reg;
    timer_next = timer_reg;
    count_next = beep_count;
    done_next  = done;
    case (state_reg)
      IDLE: begin
        if (start) begin
          state_next = ON;
          timer_next = '0;
          count_next = 4'd0;
          done_next  = 1'b0;
        end
      end
      ON: begin
        if (!sirene_req) begin
          state_next = IDLE;
          done_next  = 1'b0;
        end else if (ack) begin
          state_next = WAIT_CLEAR;
          done_next  = 1'b0;
        end else if (timer_reg == TW'(ON_CYCLES - 1)) begin
          count_next = beep_count + 4'd1;
          timer_next = '0;
          // The last ON phase is not followed by an OFF phase.
          if (count_next == 4'(MAX_BEEPS)) begin
            state_next = WAIT_CLEAR;
            done_next  = 1'b1;
          end else begin
            state_next = OFF;
          end
        end else begin
          timer_next = timer_reg + TW'(1);
        end
      end
      OFF: begin
        if (!sirene_req) begin
          state_next = IDLE;
          done_next  = 1'b0;
        end else if (ack) begin
          state_next = WAIT_CLEAR;
          done_next  = 1'b0;
        end else if (timer_reg == TW'(OFF_CYCLES - 1)) begin
          state_next = ON;
          timer_next = '0;
        end else begin
          timer_next = timer_reg + TW'(1);
        end
      end
      WAIT_CLEAR: begin
        if (!sirene_req) begin
          state_next = IDLE;
        end
      end
      default: begin
        state_next = IDLE;
        timer_next = '0;
      end
    endcase
  end

  // Outputs are registered from the next state so they line up with the state register.
  always_ff @(posedge clk_2 or negedge reset_n) begin
    if (!reset_n) begin
      state_reg  <= IDLE;
      timer_reg  <= '0;
      req_d_reg  <= 1'b1;
      buzzer     <= 1'b0;
      active     <= 1'b0;
      beep_count <= 4'd0;
      done       <= 1'b0;
    end else begin
      state_reg  <= state_next;
      timer_reg  <= timer_next;
      req_d_reg  <= sirene_req;
      buzzer     <= (state_next == ON);
      active     <= (state_next == ON) || (state_next == OFF);
      beep_count <= count_next;
      done       <= done_next;
    end
  end

endmodule

// File: tb/tb_sirene_driver.sv
// Bench for sirene_driver: directed scenarios plus random request/ack traffic,
// compared cycle by cycle against an elapsed-time model of the beep pattern.
module tb_sirene_driver;

  localparam int ON   = 4;
  localparam int OFF  = 4;
  localparam int MAXB = 3;
  localparam int PER  = ON + OFF;

  logic       clk_2 = 1'b0;
  logic       reset_n = 1'b0;
  logic       sirene_req = 1'b0;
  logic       ack = 1'b0;
  logic       buzzer, active, done;
  logic [3:0] beep_count;

  int n_checks = 0;
  int n_errors = 0;

  // Model: a running sequence is described only by cycles elapsed since its start.
  bit m_run, m_wait, m_done, m_prev;
  int m_e, m_cnt;

  always #5 clk_2 = ~clk_2;

  sirene_driver #(.ON_CYCLES(ON), .OFF_CYCLES(OFF), .MAX_BEEPS(MAXB)) dut (
    .clk_2(clk_2), .reset_n(reset_n), .sirene_req(sirene_req), .ack(ack),
    .buzzer(buzzer), .active(active), .beep_count(beep_count), .done(done)
  );

  task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0d expected %0d at t=%0t", tag, obs, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_run = 0; m_wait = 0; m_done = 0; m_prev = 1; m_e = 0; m_cnt = 0;
  endtask

  task automatic model_edge(input bit req, input bit a);
    if (m_run) begin
      if (!req) begin
        m_run = 0; m_done = 0;
      end else if (a) begin
        m_run = 0; m_wait = 1; m_done = 0;
      end else begin
        m_e++;
        m_cnt = (m_e + OFF) / PER;
        if (m_cnt == MAXB) begin
          m_run = 0; m_wait = 1; m_done = 1;
        end
      end
    end else if (m_wait) begin
      if (!req) m_wait = 0;
    end else if (req && !m_prev) begin
      m_run = 1; m_e = 0; m_cnt = 0; m_done = 0;
    end
    m_prev = req;
  endtask

  task automatic check_outputs(input string tag);
    bit exp_buz;
    exp_buz = m_run && ((m_e % PER) < ON);
    check_val({tag, ".buzzer"}, 32'(buzzer), 32'(exp_buz));
    check_val({tag, ".active"}, 32'(active), 32'(m_run));
    check_val({tag, ".beep_count"}, 32'(beep_count), 32'(m_cnt));
    check_val({tag, ".done"}, 32'(done), 32'(m_done));
  endtask

  task automatic step(input string tag, input bit req, input bit a);
    sirene_req = req;
    ack = a;
    @(posedge clk_2);
    model_edge(req, a);
    #1;
    check_outputs(tag);
    $display("%-6s t=%0t req=%0b ack=%0b buz=%0b act=%0b cnt=%0d done=%0b",
             tag, $time, req, a, buzzer, active, beep_count, done);
  endtask

  // Asynchronous reset pulse placed mid-cycle, away from any clock edge.
  task automatic reset_pulse(input string tag);
    #2 reset_n = 1'b0;
    #1 model_reset();
    check_outputs({tag, ".async"});
    @(posedge clk_2);
    #1;
    check_outputs({tag, ".held"});
    reset_n = 1'b1;
  endtask

  initial begin
    int buz_hi;
    model_reset();
    @(posedge clk_2);
    #1;
    check_outputs("reset");
    reset_n = 1'b1;
    step("idle", 0, 0);

    // Full uninterrupted sequence; also measure total ON time.
    buz_hi = 0;
    for (int i = 0; i < 26; i++) begin
      step("full", 1, 0);
      if (buzzer) buz_hi++;
    end
    check_val("full.on_time", 32'(buz_hi), 32'(MAXB * ON));
    check_val("full.done_hold", 32'(done), 32'd1);
    step("full", 0, 0);
    step("full", 0, 0);

    // Ack during second ON phase, then more ack toggles that must be ignored.
    for (int i = 0; i < 16; i++) step("ack", 1, (i == 9) || (i == 12) || (i == 13));
    check_val("ack.count", 32'(beep_count), 32'd1);
    step("ack", 0, 0);

    // Request drop during OFF, then re-rise.
    for (int i = 0; i < 14; i++) step("drop", (i < 6) || (i > 8), 0);
    step("drop", 0, 0);

    // Drop and ack together during ON, immediate re-rise must restart.
    step("both", 1, 0);
    step("both", 1, 0);
    step("both", 0, 1);
    step("both", 1, 0);
    check_val("both.restart", 32'(buzzer), 32'd1);
    step("both", 0, 0);

    // Request held through reset release: no beep until it falls and rises.
    sirene_req = 1'b1;
    reset_pulse("rhold");
    for (int i = 0; i < 4; i++) step("rhold", 1, 0);
    step("rhold", 0, 0);
    for (int i = 0; i < 3; i++) step("rhold", 1, 0);
    step("rhold", 0, 0);

    // Reset in the middle of a sequence, then no restart while request stays high.
    for (int i = 0; i < 14; i++) step("midrst", 1, 0);
    reset_pulse("midrst");
    for (int i = 0; i < 6; i++) step("midrst", 1, 0);
    step("midrst", 0, 0);

    // Random traffic.
    for (int i = 0; i < 1500; i++) begin
      bit r;
      r = ($urandom_range(0, 11) == 0) ? ~sirene_req : sirene_req;
      if ($urandom_range(0, 299) == 0) reset_pulse("rnd");
      else step("rnd", r, $urandom_range(0, 15) == 0);
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
